// File: rtl/rv_iopmp_pkg.sv
// Shared types for IOPMP error reporting: the buffered violation record and the capture-side view.
package rv_iopmp_pkg;

    localparam int ERR_TTYPE_W = 2;
    localparam int ERR_ETYPE_W = 3;
    localparam int ERR_ID_W    = 16;
    localparam int ERR_ADDR_W  = 32;

    typedef struct packed {
        logic [ERR_TTYPE_W-1:0] ttype;
        logic [ERR_ETYPE_W-1:0] etype;
        logic [ERR_ID_W-1:0]    sid;
        logic [ERR_ID_W-1:0]    eid;
        logic [ERR_ADDR_W-1:0]  reqaddr;
        logic [ERR_ADDR_W-1:0]  reqaddrh;
    } err_record_t;

    typedef struct packed {
        logic                   error_detected;
        logic [ERR_TTYPE_W-1:0] ttype;
        logic [ERR_ETYPE_W-1:0] etype;
        logic [ERR_ID_W-1:0]    sid;
        logic [ERR_ID_W-1:0]    eid;
        logic [ERR_ADDR_W-1:0]  err_reqaddr;
        logic [ERR_ADDR_W-1:0]  err_reqaddrh;
    } error_capture_t;

    // addr_word is the byte address with its two LSBs already stripped (addr[63:2]).
    function automatic err_record_t pack_err_record(
        input logic [61:0]            addr_word,
        input logic [ERR_TTYPE_W-1:0] ttype,
        input logic [ERR_ETYPE_W-1:0] etype,
        input logic [ERR_ID_W-1:0]    sid,
        input logic [ERR_ID_W-1:0]    eid
    );
        err_record_t rec;
        rec.ttype    = ttype;
        rec.etype    = etype;
        rec.sid      = sid;
        rec.eid      = eid;
        rec.reqaddr  = addr_word[31:0];
        rec.reqaddrh = {2'b00, addr_word[61:32]};
        return rec;
    endfunction

endpackage

// File: rtl/rv_iopmp_err_fifo.sv
// Circular buffer of violation records with occupancy counter and synchronous flush.
module rv_iopmp_err_fifo
    import rv_iopmp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        push_i,
    input  err_record_t wdata_i,
    input  logic        pop_i,
    output err_record_t rdata_o,
    output logic        empty_o,
    output logic        full_o,
    output logic        one_left_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    err_record_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty_o    = (count == '0);
    assign full_o     = (count == CNT_W'(DEPTH));
    assign one_left_o = (count == CNT_W'(1));
    assign do_pop     = pop_i & ~empty_o;
    assign do_push    = push_i & (~full_o | do_pop);
    assign rdata_o    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it until the occupancy counter says it is valid.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem[wr_ptr] <= wdata_i;
    end

endmodule

// File: rtl/rv_iopmp_error_reporter.sv
// Producer end of the IOPMP error-capture interface: buffers violations, presents the oldest,
// and counts records lost to overflow.
//   state   | meaning
//   IDLE    | FIFO empty, err_o all-zero
//   PRESENT | head record driven on err_o until acked
module rv_iopmp_error_reporter
    import rv_iopmp_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   enable_i,
    input  logic                   viol_valid_i,
    input  logic [ERR_TTYPE_W-1:0] viol_ttype_i,
    input  logic [ERR_ETYPE_W-1:0] viol_etype_i,
    input  logic [ERR_ID_W-1:0]    viol_sid_i,
    input  logic [ERR_ID_W-1:0]    viol_eid_i,
    input  logic [63:0]            viol_addr_i,
    output error_capture_t         err_o,
    input  logic                   err_ack_i,
    output logic [CNT_WIDTH-1:0]   drop_cnt_o,
    input  logic                   drop_clr_i,
    output logic                   busy_o
);

    typedef enum logic {IDLE = 1'b0, PRESENT = 1'b1} state_t;

    state_t         state_q, state_d;
    err_record_t    wdata;
    err_record_t    head;
    logic           empty, full, one_left;
    logic           push, pop, drop;
    logic           unused_addr_lsb;

    assign unused_addr_lsb = ^viol_addr_i[1:0];
    assign wdata = pack_err_record(viol_addr_i[63:2], viol_ttype_i, viol_etype_i,
                                   viol_sid_i, viol_eid_i);

    assign pop  = err_ack_i & (state_q == PRESENT);
    assign push = viol_valid_i & enable_i & (~full | pop);
    assign drop = viol_valid_i & enable_i & full & ~pop;

    rv_iopmp_err_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_i    (~enable_i),
        .push_i     (push),
        .wdata_i    (wdata),
        .pop_i      (pop),
        .rdata_o    (head),
        .empty_o    (empty),
        .full_o     (full),
        .one_left_o (one_left)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        err_o   = '0;
        unique case (state_q)
            IDLE: begin
                if (push) state_d = PRESENT;
            end
            PRESENT: begin
                err_o.error_detected = 1'b1;
                err_o.ttype          = head.ttype;
                err_o.etype          = head.etype;
                err_o.sid            = head.sid;
                err_o.eid            = head.eid;
                err_o.err_reqaddr    = head.reqaddr;
                err_o.err_reqaddrh   = head.reqaddrh;
                if (!enable_i || (pop && one_left && !push)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = ~empty;

    // A drop in the same cycle as a clear survives as a single count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            drop_cnt_o <= '0;
        end else if (drop) begin
            if (drop_clr_i)             drop_cnt_o <= CNT_WIDTH'(1);
            else if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + CNT_WIDTH'(1);
        end else if (drop_clr_i) begin
            drop_cnt_o <= '0;
        end
    end

endmodule

// File: tb/tb_rv_iopmp_error_reporter.sv
// Directed bench for rv_iopmp_error_reporter (DEPTH=4, CNT_WIDTH=2).
module tb_rv_iopmp_error_reporter;
    import rv_iopmp_pkg::*;

    logic           clk_i = 1'b0;
    logic           rst_ni;
    logic           enable_i;
    logic           viol_valid_i;
    logic [1:0]     viol_ttype_i;
    logic [2:0]     viol_etype_i;
    logic [15:0]    viol_sid_i;
    logic [15:0]    viol_eid_i;
    logic [63:0]    viol_addr_i;
    error_capture_t err_o;
    logic           err_ack_i;
    logic [1:0]     drop_cnt_o;
    logic           drop_clr_i;
    logic           busy_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk_i = ~clk_i;

    rv_iopmp_error_reporter #(.DEPTH(4), .CNT_WIDTH(2)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .enable_i     (enable_i),
        .viol_valid_i (viol_valid_i),
        .viol_ttype_i (viol_ttype_i),
        .viol_etype_i (viol_etype_i),
        .viol_sid_i   (viol_sid_i),
        .viol_eid_i   (viol_eid_i),
        .viol_addr_i  (viol_addr_i),
        .err_o        (err_o),
        .err_ack_i    (err_ack_i),
        .drop_cnt_o   (drop_cnt_o),
        .drop_clr_i   (drop_clr_i),
        .busy_o       (busy_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_viol(input logic [15:0] eid);
        viol_valid_i = 1'b1;
        viol_ttype_i = 2'd1;
        viol_etype_i = 3'd2;
        viol_sid_i   = 16'd7;
        viol_eid_i   = eid;
        viol_addr_i  = 64'h0000_0000_0000_1000 + {48'd0, eid};
    endtask

    // Push n consecutive records with eids first..first+n-1, one per cycle.
    task automatic push_seq(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            set_viol(16'(first + i));
            step();
        end
        viol_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0; enable_i = 1'b1; viol_valid_i = 1'b0; viol_ttype_i = '0;
        viol_etype_i = '0; viol_sid_i = '0; viol_eid_i = '0; viol_addr_i = '0;
        err_ack_i = 1'b0; drop_clr_i = 1'b0;
        step(); step();
        total_cnt++;
        if (err_o !== '0) $display("FAIL reset_err_o got=%h exp=0", err_o); else pass_cnt++;
        total_cnt++;
        if (drop_cnt_o !== 2'd0 || busy_o !== 1'b0)
            $display("FAIL reset_cnt_busy got=%0d/%b exp=0/0", drop_cnt_o, busy_o); else pass_cnt++;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_single();
        viol_valid_i = 1'b1; viol_ttype_i = 2'd2; viol_etype_i = 3'd5;
        viol_sid_i = 16'd5; viol_eid_i = 16'd3; viol_addr_i = 64'h0000_0001_2345_6788;
        step();
        viol_valid_i = 1'b0;
        total_cnt++;
        if (err_o.error_detected !== 1'b1 || err_o.sid !== 16'd5 || err_o.eid !== 16'd3 ||
            err_o.ttype !== 2'd2 || err_o.etype !== 3'd5)
            $display("FAIL single_fields got=%h exp det=1 sid=5 eid=3 tt=2 et=5", err_o); else pass_cnt++;
        total_cnt++;
        if (err_o.err_reqaddr !== 32'h48D1_59E2 || err_o.err_reqaddrh !== 32'h0)
            $display("FAIL single_addr got=%h/%h exp=48d159e2/0", err_o.err_reqaddr, err_o.err_reqaddrh);
        else pass_cnt++;
        for (int i = 0; i < 2; i++) begin
            step();
            total_cnt++;
            if (err_o.error_detected !== 1'b1 || err_o.eid !== 16'd3 || err_o.err_reqaddr !== 32'h48D1_59E2)
                $display("FAIL single_stable%0d got=%h exp det=1 eid=3", i, err_o); else pass_cnt++;
        end
        err_ack_i = 1'b1;
        step();
        err_ack_i = 1'b0;
        total_cnt++;
        if (err_o !== '0 || busy_o !== 1'b0)
            $display("FAIL single_cleared got=%h busy=%b exp=0/0", err_o, busy_o); else pass_cnt++;
    endtask

    task automatic test_overflow_order();
        push_seq(0, 6);
        total_cnt++;
        if (drop_cnt_o !== 2'd2) $display("FAIL ovf_drop got=%0d exp=2", drop_cnt_o); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++;
            if (err_o.error_detected !== 1'b1 || err_o.eid !== 16'(i))
                $display("FAIL ovf_order%0d got det=%b eid=%0d exp det=1 eid=%0d",
                         i, err_o.error_detected, err_o.eid, i);
            else pass_cnt++;
            err_ack_i = 1'b1;
            step();
            err_ack_i = 1'b0;
        end
        total_cnt++;
        if (err_o.error_detected !== 1'b0 || busy_o !== 1'b0)
            $display("FAIL ovf_drained got det=%b busy=%b exp=0/0", err_o.error_detected, busy_o);
        else pass_cnt++;
        drop_clr_i = 1'b1;
        step();
        drop_clr_i = 1'b0;
        total_cnt++;
        if (drop_cnt_o !== 2'd0) $display("FAIL ovf_clr got=%0d exp=0", drop_cnt_o); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        push_seq(10, 4);
        set_viol(16'd14);
        err_ack_i = 1'b1;
        step();
        viol_valid_i = 1'b0;
        err_ack_i = 1'b0;
        total_cnt++;
        if (drop_cnt_o !== 2'd0 || err_o.eid !== 16'd11)
            $display("FAIL b2b_nodrop got drop=%0d head=%0d exp=0/11", drop_cnt_o, err_o.eid); else pass_cnt++;
        for (int i = 11; i <= 14; i++) begin
            total_cnt++;
            if (err_o.error_detected !== 1'b1 || err_o.eid !== 16'(i))
                $display("FAIL b2b_order%0d got det=%b eid=%0d exp det=1", i, err_o.error_detected, err_o.eid);
            else pass_cnt++;
            err_ack_i = 1'b1;
            step();
            err_ack_i = 1'b0;
        end
        total_cnt++;
        if (busy_o !== 1'b0) $display("FAIL b2b_empty got busy=%b exp=0", busy_o); else pass_cnt++;
    endtask

    task automatic test_saturate();
        push_seq(30, 9);
        total_cnt++;
        if (drop_cnt_o !== 2'd3) $display("FAIL sat_cnt got=%0d exp=3", drop_cnt_o); else pass_cnt++;
        total_cnt++;
        if (err_o.eid !== 16'd30) $display("FAIL sat_oldest got=%0d exp=30", err_o.eid); else pass_cnt++;
        drop_clr_i = 1'b1;
        step();
        total_cnt++;
        if (drop_cnt_o !== 2'd0) $display("FAIL sat_clr got=%0d exp=0", drop_cnt_o); else pass_cnt++;
        set_viol(16'd50);
        step();
        viol_valid_i = 1'b0;
        drop_clr_i = 1'b0;
        total_cnt++;
        if (drop_cnt_o !== 2'd1) $display("FAIL sat_clr_drop got=%0d exp=1", drop_cnt_o); else pass_cnt++;
    endtask

    task automatic test_disable();
        enable_i = 1'b0;
        step();
        enable_i = 1'b1;
        step();
        push_seq(20, 3);
        total_cnt++;
        if (busy_o !== 1'b1 || err_o.eid !== 16'd20)
            $display("FAIL dis_prefill got busy=%b eid=%0d exp=1/20", busy_o, err_o.eid); else pass_cnt++;
        enable_i = 1'b0;
        step();
        total_cnt++;
        if (err_o !== '0 || busy_o !== 1'b0)
            $display("FAIL dis_flush got=%h busy=%b exp=0/0", err_o, busy_o); else pass_cnt++;
        set_viol(16'd60);
        step();
        viol_valid_i = 1'b0;
        total_cnt++;
        if (busy_o !== 1'b0 || drop_cnt_o !== 2'd1)
            $display("FAIL dis_ignore got busy=%b drop=%0d exp=0/1", busy_o, drop_cnt_o); else pass_cnt++;
        enable_i = 1'b1;
        step();
        total_cnt++;
        if (err_o.error_detected !== 1'b0) $display("FAIL dis_reenable got det=%b exp=0", err_o.error_detected);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        push_seq(40, 2);
        #2;
        rst_ni = 1'b0;
        #1;
        total_cnt++;
        if (err_o !== '0 || busy_o !== 1'b0 || drop_cnt_o !== 2'd0)
            $display("FAIL arst_immediate got=%h busy=%b drop=%0d exp=0/0/0", err_o, busy_o, drop_cnt_o);
        else pass_cnt++;
        step();
        rst_ni = 1'b1;
        step();
        set_viol(16'd77);
        step();
        viol_valid_i = 1'b0;
        total_cnt++;
        if (err_o.error_detected !== 1'b1 || err_o.eid !== 16'd77 || err_o.err_reqaddr !== 32'h0000_0413)
            $display("FAIL arst_first got det=%b eid=%0d addr=%h exp=1/77/00000413",
                     err_o.error_detected, err_o.eid, err_o.err_reqaddr);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_overflow_order();
        test_back_to_back();
        test_saturate();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
